// File: rtl/inst_cache_core.sv
// Direct-mapped, read-only instruction cache: 1-cycle lookup, 8-word burst refill, uncached bypass.
// Optional INST_CACHE_PERF_EN adds hit_cnt/miss_cnt outputs counting cached lookups.
module inst_cache_core #(
  parameter int LINE_OFFSET_WIDTH = 5,
  parameter int INDEX_WIDTH       = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cache_ena,
  input  logic [31:0] s_araddr,
  input  logic        s_arvalid,
  input  logic        flush,
  output logic [31:0] s_rdata,
  output logic        s_rvalid,
  output logic [31:0] m_araddr,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic        m_rvalid,
  input  logic        m_rlast,
  output logic        m_rready
`ifdef INST_CACHE_PERF_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int WW    = LINE_OFFSET_WIDTH - 2;
  localparam int WORDS = 1 << WW;
  localparam int SETS  = 1 << INDEX_WIDTH;
  localparam int TAG_W = 32 - INDEX_WIDTH - LINE_OFFSET_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_MISS_REQ, S_REFILL, S_RESP, S_UNC_REQ, S_UNC_WAIT
  } state_t;

  state_t r_state, w_next;

  logic [31:0]      r_addr;
  logic             r_cached;
  logic             r_dead;
  logic [WW:0]      r_beat;
  logic [31:0]      r_unc_data;
  logic             r_unc_got;
  logic             r_s_rvalid;
  logic [31:0]      r_s_rdata;
  logic [SETS-1:0]  r_valid;
  logic [TAG_W-1:0] r_tag  [SETS];
  logic [31:0]      r_data [SETS][WORDS];

  logic [INDEX_WIDTH-1:0] w_idx;
  logic [TAG_W-1:0]       w_tag;
  logic [WW-1:0]          w_word;
  logic                   w_hit;
  logic                   w_accept;
  logic                   w_kill;
  logic                   w_last;
  logic                   w_beat_wr;

  // Every decision after acceptance uses the latched address only.
  assign w_idx     = r_addr[INDEX_WIDTH+LINE_OFFSET_WIDTH-1:LINE_OFFSET_WIDTH];
  assign w_tag     = r_addr[31:INDEX_WIDTH+LINE_OFFSET_WIDTH];
  assign w_word    = r_addr[LINE_OFFSET_WIDTH-1:2];
  assign w_hit     = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_accept  = (r_state == S_IDLE) && s_arvalid && !flush;
  assign w_kill    = r_dead || flush;
  assign w_last    = m_rvalid && m_rlast;
  assign w_beat_wr = (r_state == S_REFILL) && m_rvalid && !r_beat[WW];

  assign s_rvalid = r_s_rvalid;
  assign s_rdata  = r_s_rdata;

  always_comb begin
    w_next    = r_state;
    m_arvalid = 1'b0;
    m_araddr  = 32'd0;
    m_rready  = 1'b0;
    case (r_state)
      S_IDLE:     if (w_accept) w_next = cache_ena ? S_LOOKUP : S_UNC_REQ;
      S_LOOKUP:   w_next = (w_kill || w_hit) ? S_IDLE : S_MISS_REQ;
      S_MISS_REQ: begin
        m_arvalid = 1'b1;
        m_araddr  = {r_addr[31:LINE_OFFSET_WIDTH], {LINE_OFFSET_WIDTH{1'b0}}};
        if (m_arready) w_next = S_REFILL;
      end
      S_REFILL: begin
        m_rready = 1'b1;
        if (w_last) w_next = w_kill ? S_IDLE : S_RESP;
      end
      S_RESP:     w_next = S_IDLE;
      S_UNC_REQ: begin
        m_arvalid = 1'b1;
        m_araddr  = r_addr;
        if (m_arready) w_next = S_UNC_WAIT;
      end
      S_UNC_WAIT: begin
        m_rready = 1'b1;
        if (w_last) w_next = w_kill ? S_IDLE : S_RESP;
      end
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_addr     <= 32'd0;
      r_cached   <= 1'b0;
      r_dead     <= 1'b0;
      r_beat     <= '0;
      r_unc_data <= 32'd0;
      r_unc_got  <= 1'b0;
      r_s_rvalid <= 1'b0;
      r_s_rdata  <= 32'd0;
      r_valid    <= '0;
    end else begin
      r_state    <= w_next;
      r_s_rvalid <= 1'b0;
      if (w_accept) begin
        r_addr   <= s_araddr;
        r_cached <= cache_ena;
        r_dead   <= 1'b0;
      end else if (flush && r_state != S_IDLE) begin
        r_dead <= 1'b1;
      end
      case (r_state)
        S_LOOKUP: if (w_hit && !w_kill) begin
          r_s_rvalid <= 1'b1;
          r_s_rdata  <= r_data[w_idx][w_word];
        end
        S_MISS_REQ: begin
          r_beat <= '0;
          // The line is about to be overwritten; drop it until the new tag lands.
          if (m_arready) r_valid[w_idx] <= 1'b0;
        end
        S_REFILL: begin
          if (w_beat_wr) r_beat <= r_beat + (WW+1)'(1);
          if (w_last) r_valid[w_idx] <= 1'b1;
        end
        S_RESP: if (!w_kill) begin
          r_s_rvalid <= 1'b1;
          r_s_rdata  <= r_cached ? r_data[w_idx][w_word] : r_unc_data;
        end
        S_UNC_REQ: r_unc_got <= 1'b0;
        S_UNC_WAIT: if (m_rvalid && !r_unc_got) begin
          r_unc_data <= m_rdata;
          r_unc_got  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Tag and data arrays carry no reset; the valid bits gate their use.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_beat_wr) r_data[w_idx][r_beat[WW-1:0]] <= m_rdata;
      if (r_state == S_REFILL && w_last) r_tag[w_idx] <= w_tag;
    end
  end

`ifdef INST_CACHE_PERF_EN
  logic [31:0] r_hit_cnt, r_miss_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_cnt  <= 32'd0;
      r_miss_cnt <= 32'd0;
    end else if (r_state == S_LOOKUP) begin
      if (w_hit) r_hit_cnt  <= r_hit_cnt + 32'd1;
      else       r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end
  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_inst_cache_core.sv
// Scoreboard bench for inst_cache_core: memory model returns the word address for every beat.
module tb_inst_cache_core;
  logic        clk = 1'b0;
  logic        rst;
  logic        cache_ena;
  logic [31:0] s_araddr;
  logic        s_arvalid;
  logic        flush;
  logic [31:0] s_rdata;
  logic        s_rvalid;
  logic [31:0] m_araddr;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_rdata;
  logic        m_rvalid;
  logic        m_rlast;
  logic        m_rready;
`ifdef INST_CACHE_PERF_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  inst_cache_core dut (
    .clk(clk), .rst(rst), .cache_ena(cache_ena), .s_araddr(s_araddr), .s_arvalid(s_arvalid),
    .flush(flush), .s_rdata(s_rdata), .s_rvalid(s_rvalid), .m_araddr(m_araddr),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_rdata(m_rdata), .m_rvalid(m_rvalid),
    .m_rlast(m_rlast), .m_rready(m_rready)
`ifdef INST_CACHE_PERF_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] sb[$];
  logic [31:0] reqs[$];
  int          mem_len  = 8;
  bit          mem_busy = 0;

  // Memory: accept address, then beat k = addr + 4k, with one idle cycle before beat 3.
  initial begin
    logic [31:0] a;
    m_arready = 0; m_rvalid = 0; m_rlast = 0; m_rdata = 0;
    forever begin
      @(negedge clk);
      if (!rst && m_arvalid) begin
        mem_busy = 1; m_arready = 1; a = m_araddr; reqs.push_back(a);
        @(negedge clk);
        m_arready = 0;
        for (int k = 0; k < mem_len; k++) begin
          if (k == 3) begin m_rvalid = 0; m_rlast = 0; @(negedge clk); end
          m_rvalid = 1; m_rdata = a + 32'(4 * k); m_rlast = (k == mem_len - 1);
          @(negedge clk);
        end
        m_rvalid = 0; m_rlast = 0; mem_busy = 0;
      end
    end
  end

  // Response monitor: every s_rvalid pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && s_rvalid) begin
      n_checks++;
      if (sb.size() == 0) $display("FAIL unexpected_rvalid: got s_rdata=%h, required no response", s_rdata);
      else begin
        logic [31:0] e;
        e = sb.pop_front();
        if (s_rdata !== e) $display("FAIL rdata: got %h, required %h", s_rdata, e);
        else n_pass++;
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic ena, input bit wait_resp, output int lat);
    @(negedge clk);
    s_araddr = a; cache_ena = ena; s_arvalid = 1;
    @(posedge clk); #1;
    s_arvalid = 0; s_araddr = ~a; cache_ena = ~ena;
    lat = 1;
    if (wait_resp) begin
      sb.push_back(a);
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (s_rvalid) break;
        @(posedge clk);
        lat++;
      end
    end
  endtask

  task automatic wait_mem_idle();
    for (int i = 0; i < 100 && mem_busy; i++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; cache_ena = 1; s_araddr = 0; s_arvalid = 0; flush = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (s_rvalid !== 1'b0) $display("FAIL rst_rvalid: got %b, required 0", s_rvalid); else n_pass++;
    n_checks++; if (s_rdata !== 32'd0) $display("FAIL rst_rdata: got %h, required 0", s_rdata); else n_pass++;
    n_checks++; if (m_arvalid !== 1'b0) $display("FAIL rst_arvalid: got %b, required 0", m_arvalid); else n_pass++;
    n_checks++; if (m_araddr !== 32'd0) $display("FAIL rst_araddr: got %h, required 0", m_araddr); else n_pass++;
    n_checks++; if (m_rready !== 1'b0) $display("FAIL rst_rready: got %b, required 0", m_rready); else n_pass++;
`ifdef INST_CACHE_PERF_EN
    n_checks++; if (hit_cnt !== 0 || miss_cnt !== 0) $display("FAIL rst_cnt: got %0d/%0d, required 0/0", hit_cnt, miss_cnt); else n_pass++;
`endif
    rst = 0;
  endtask

  task automatic check_miss(input string nm, input logic [31:0] a, input logic [31:0] line, input int exp_lat);
    int n0, lat;
    n0 = reqs.size();
    issue(a, 1'b1, 1'b1, lat);
    n_checks++; if (reqs.size() != n0 + 1) $display("FAIL %s_reqs: got %0d bus requests, required 1", nm, reqs.size() - n0); else n_pass++;
    n_checks++; if (reqs.size() == 0 || reqs[$] !== line) $display("FAIL %s_araddr: got %h, required %h", nm, (reqs.size() != 0) ? reqs[$] : 32'hx, line); else n_pass++;
    n_checks++; if (lat != exp_lat) $display("FAIL %s_lat: got %0d, required %0d", nm, lat, exp_lat); else n_pass++;
  endtask

  task automatic check_hit(input string nm, input logic [31:0] a);
    int n0, lat;
    n0 = reqs.size();
    issue(a, 1'b1, 1'b1, lat);
    n_checks++; if (reqs.size() != n0) $display("FAIL %s_reqs: got %0d bus requests, required 0", nm, reqs.size() - n0); else n_pass++;
    n_checks++; if (lat != 2) $display("FAIL %s_lat: got %0d, required 2", nm, lat); else n_pass++;
  endtask

  task automatic test_cached();
    check_miss("cold", 32'hf000_0000, 32'hf000_0000, 13);
    check_hit("hit4", 32'hf000_0004);
    check_hit("hit8", 32'hf000_0008);
    check_hit("hitC", 32'hf000_000C);
    check_miss("miss40", 32'hf000_0040, 32'hf000_0040, 13);
    check_hit("hit44", 32'hf000_0044);
  endtask

  task automatic test_flush();
    int n0, lat;
    bit seen;
    n0 = reqs.size();
    @(negedge clk); s_araddr = 32'hf000_0100; cache_ena = 1; s_arvalid = 1; flush = 1;
    @(negedge clk); s_arvalid = 0; flush = 0;
    repeat (5) @(negedge clk);
    n_checks++; if (reqs.size() != n0) $display("FAIL flush_idle: got %0d bus requests, required 0", reqs.size() - n0); else n_pass++;
    issue(32'hf000_0080, 1'b1, 1'b0, lat);
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin @(negedge clk); seen = m_rready; end
    n_checks++; if (!seen) $display("FAIL flush_refill_start: got m_rready=0, required 1"); else n_pass++;
    @(negedge clk); flush = 1;
    @(negedge clk); flush = 0;
    wait_mem_idle();
    n_checks++; if (reqs.size() != n0 + 1) $display("FAIL flush_reqs: got %0d bus requests, required 1", reqs.size() - n0); else n_pass++;
    check_hit("flush_hit80", 32'hf000_0080);
    check_hit("flush_hit84", 32'hf000_0084);
  endtask

  task automatic test_uncached();
    int n0, lat;
    mem_len = 1;
    for (int r = 0; r < 2; r++) begin
      n0 = reqs.size();
      issue(32'h0000_0014, 1'b0, 1'b1, lat);
      n_checks++; if (reqs.size() != n0 + 1) $display("FAIL unc%0d_reqs: got %0d bus requests, required 1", r, reqs.size() - n0); else n_pass++;
      n_checks++; if (reqs.size() == 0 || reqs[$] !== 32'h0000_0014) $display("FAIL unc%0d_araddr: got %h, required 00000014", r, (reqs.size() != 0) ? reqs[$] : 32'hx); else n_pass++;
      n_checks++; if (lat != 4) $display("FAIL unc%0d_lat: got %0d, required 4", r, lat); else n_pass++;
    end
    mem_len = 8;
  endtask

  task automatic test_evict();
    mem_len = 10;
    check_miss("evict", 32'hf000_1000, 32'hf000_1000, 15);
    mem_len = 8;
    check_hit("evict_hit4", 32'hf000_1004);
    check_miss("refetch", 32'hf000_0000, 32'hf000_0000, 13);
  endtask

  task automatic test_reset_mid_refill();
    int lat;
    bit seen;
    issue(32'hf000_0300, 1'b1, 1'b0, lat);
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin @(negedge clk); seen = m_rready; end
    @(negedge clk); @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    n_checks++; if (m_rready !== 1'b0 || !seen) $display("FAIL midrst_rready: got %b, required 0 after reset", m_rready); else n_pass++;
    wait_mem_idle();
    check_miss("midrst_miss", 32'hf000_0004, 32'hf000_0000, 13);
    check_hit("midrst_hit8", 32'hf000_0008);
  endtask

  initial begin
    test_reset();
    test_cached();
    test_flush();
    test_uncached();
    test_evict();
    test_reset_mid_refill();
    repeat (5) @(negedge clk);
    n_checks++; if (sb.size() != 0) $display("FAIL sb_drain: got %0d outstanding, required 0", sb.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
